// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA timing core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default 640x480@60 timing constants, the pattern mode enum and
// a helper that sums a timing group into its total period.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_COLOR_W  = 4;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_WHITE = 2'd3
  } vga_mode_e;

  // Total period of one timing group (H_TOTAL or V_TOTAL).
  function automatic int vga_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational colour source: external pass-through or a built-in test pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows x/y/mode directly.
//
// Ports:
//   x, y              current pixel coordinate
//   mode              pattern select (external / bars / checkerboard / white)
//   ext_r/g/b         external colour, passed through in MODE_EXT
//   r, g, b           selected colour (blanking is applied by the caller)
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  vga_mode_e          mode,
  input  logic [COLOR_W-1:0] ext_r,
  input  logic [COLOR_W-1:0] ext_g,
  input  logic [COLOR_W-1:0] ext_b,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam logic [COLOR_W-1:0] ONES = {COLOR_W{1'b1}};

  logic [31:0] x_w;
  logic [31:0] y_w;
  logic [31:0] bar_idx;
  logic [2:0]  bar_code;
  logic        check_on;
  logic        unused_bits;

  assign x_w = 32'(x);
  assign y_w = 32'(y);

  // Eight equal-width bars across the active line; only indices 0..7 are
  // ever displayed, out-of-range values land in the blanking interval.
  assign bar_idx  = (x_w * 32'd8) / 32'(H_ACTIVE);
  assign bar_code = 3'd7 - bar_idx[2:0];

  // 32-pixel squares.
  assign check_on = x_w[5] ^ y_w[5];

  assign unused_bits = ^{bar_idx[31:3], y_w[31:6], y_w[4:0]};

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (mode)
      MODE_EXT: begin
        r = ext_r;
        g = ext_g;
        b = ext_b;
      end
      MODE_BARS: begin
        r = bar_code[2] ? ONES : '0;
        g = bar_code[1] ? ONES : '0;
        b = bar_code[0] ? ONES : '0;
      end
      MODE_CHECK: begin
        r = check_on ? ONES : '0;
        g = check_on ? ONES : '0;
        b = check_on ? ONES : '0;
      end
      MODE_WHITE: begin
        r = ONES;
        g = ONES;
        b = ONES;
      end
      default: begin
        r = '0;
        g = '0;
        b = '0;
      end
    endcase
  end

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator with blanked, sync-aligned colour output.
// Latency: one pixel (one pix_ce) from coordinate request to VGA pins.
// Backpressure: none; free-running raster, ext_* must be valid by the next pix_ce.
//
// Ports:
//   CLK100MHZ, CPU_RESETN   system clock, async active-low reset
//   mode                    pattern select, latched at frame start
//   ext_r/g/b               external colour for the coordinate on pix_x/pix_y
//   pix_x/pix_y, pix_req    requested coordinate and active-area flag
//   pix_ce, frame_start     pixel strobe and start-of-frame pulse
//   VGA_R/G/B, VGA_HS/VS    registered pin outputs
// Build option: define VGA_PATTERN_EN to compile in the test pattern generator
// and mode latch; without it mode is ignored and colour always comes from ext_*.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = DEF_COLOR_W,
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] ext_r,
  input  logic [COLOR_W-1:0] ext_g,
  input  logic [COLOR_W-1:0] ext_b,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic               pix_req,
  output logic               pix_ce,
  output logic               frame_start,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]  H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]  V_LAST   = Y_W'(V_TOTAL - 1);

  localparam logic [31:0] H_ACT_U = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_U = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]   div_cnt;
  logic [X_W-1:0]     hcnt;
  logic [Y_W-1:0]     vcnt;
  logic [31:0]        hcnt_w;
  logic [31:0]        vcnt_w;
  logic               hs_raw;
  logic               vs_raw;
  logic               h_wrap;
  logic [COLOR_W-1:0] col_r;
  logic [COLOR_W-1:0] col_g;
  logic [COLOR_W-1:0] col_b;

  // ---------------------------------------------------------------- timing
  assign pix_ce = (div_cnt == DIV_LAST);
  assign h_wrap = (hcnt == H_LAST);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_cnt <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
      if (pix_ce) begin
        hcnt <= h_wrap ? '0 : hcnt + 1'b1;
        if (h_wrap) begin
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
      end
    end
  end

  assign hcnt_w      = 32'(hcnt);
  assign vcnt_w      = 32'(vcnt);
  assign pix_x       = hcnt;
  assign pix_y       = vcnt;
  assign pix_req     = (hcnt_w < H_ACT_U) && (vcnt_w < V_ACT_U);
  assign hs_raw      = (hcnt_w >= HS_BEG) && (hcnt_w < HS_END);
  assign vs_raw      = (vcnt_w >= VS_BEG) && (vcnt_w < VS_END);
  assign frame_start = pix_ce && (hcnt == '0) && (vcnt == '0);

  // ---------------------------------------------------------- colour source
`ifdef VGA_PATTERN_EN
  vga_mode_e mode_q;
  vga_mode_e mode_eff;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      mode_q <= MODE_EXT;
    end else if (frame_start) begin
      mode_q <= vga_mode_e'(mode);
    end
  end

  // Pixel (0,0) is registered on the same edge that latches mode, so it
  // uses the incoming value directly to keep the whole frame consistent.
  assign mode_eff = frame_start ? vga_mode_e'(mode) : mode_q;

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .COLOR_W  (COLOR_W),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_pattern_gen (
    .x     (hcnt),
    .y     (vcnt),
    .mode  (mode_eff),
    .ext_r (ext_r),
    .ext_g (ext_g),
    .ext_b (ext_b),
    .r     (col_r),
    .g     (col_g),
    .b     (col_b)
  );
`else
  logic unused_mode;

  assign unused_mode = ^mode;
  assign col_r       = ext_r;
  assign col_g       = ext_g;
  assign col_b       = ext_b;
`endif

  // ------------------------------------------------------------ pin stage
  // Colour and both syncs share one register stage so they stay aligned.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= ~SYNC_POL;
      VGA_VS <= ~SYNC_POL;
    end else if (pix_ce) begin
      VGA_R  <= pix_req ? col_r : '0;
      VGA_G  <= pix_req ? col_g : '0;
      VGA_B  <= pix_req ? col_b : '0;
      VGA_HS <= hs_raw ? SYNC_POL : ~SYNC_POL;
      VGA_VS <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core using a reduced raster so whole frames
// fit in a short run. Instance a: CLK_DIV=4, active-low syncs. Instance b:
// CLK_DIV=2, active-high syncs. Both use H 40/2/4/2 (48) and V 34/1/2/1 (38).
module tb_vga_timing_core;

  localparam int HA = 40, HF = 2, HS = 4, HB = 2;
  localparam int VA = 34, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 48
  localparam int VT = VA + VF + VS + VB;   // 38

  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN;
  logic [1:0] mode;
  logic [3:0] ext_r, ext_g, ext_b;

  logic [5:0] a_x, b_x;
  logic [5:0] a_y, b_y;
  logic       a_req, a_ce, a_fs, a_hs, a_vs;
  logic       b_req, b_ce, b_fs, b_hs, b_vs;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  vga_timing_core #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(4)
  ) dut_a (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .mode(mode),
    .ext_r(ext_r), .ext_g(ext_g), .ext_b(ext_b),
    .pix_x(a_x), .pix_y(a_y), .pix_req(a_req), .pix_ce(a_ce),
    .frame_start(a_fs), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .VGA_HS(a_hs), .VGA_VS(a_vs)
  );

  vga_timing_core #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .COLOR_W(4)
  ) dut_b (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .mode(mode),
    .ext_r(ext_r), .ext_g(ext_g), .ext_b(ext_b),
    .pix_x(b_x), .pix_y(b_y), .pix_req(b_req), .pix_ce(b_ce),
    .frame_start(b_fs), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs)
  );

  // Advance to the next negedge on which the selected instance strobes pix_ce.
  task automatic next_ce(input bit sel, output bit ok);
    int n = 0;
    do begin
      @(negedge CLK100MHZ);
      n++;
      ok = sel ? b_ce : a_ce;
    end while (!ok && n < 100);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL next_ce[%0d] timeout: strobe seen=%0b required=1", sel, ok);
    end
  endtask

  // Advance to the negedge where pix_ce is high with the coordinate (x,y);
  // the registered pins for that pixel are visible one negedge later.
  task automatic goto_pixel(input bit sel, input int x, input int y, output bit ok);
    int n = 0;
    do begin
      @(negedge CLK100MHZ);
      n++;
      if (sel) ok = b_ce && (int'(b_x) == x) && (int'(b_y) == y);
      else     ok = a_ce && (int'(a_x) == x) && (int'(a_y) == y);
    end while (!ok && n < 16000);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL goto[%0d] (%0d,%0d) timeout: reached=%0b required=1", sel, x, y, ok);
    end
  endtask

  task automatic test_reset();
    CPU_RESETN = 1'b1;
    mode  = 2'd0;
    ext_r = 4'h5; ext_g = 4'hA; ext_b = 4'h3;
    #1 CPU_RESETN = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    n_checks++;
    if ({a_ce, a_fs, b_ce, b_fs} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 0000", {a_ce, a_fs, b_ce, b_fs});
    end
    n_checks++;
    if ({a_x, a_y} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_coord got x=%0d y=%0d want 0,0", a_x, a_y);
    end
    n_checks++;
    if ({a_r, a_g, a_b, b_r, b_g, b_b} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_rgb got %h want 0", {a_r, a_g, a_b, b_r, b_g, b_b});
    end
    n_checks++;
    if ({a_hs, a_vs, b_hs, b_vs} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_sync got %b want 1100", {a_hs, a_vs, b_hs, b_vs});
    end
  endtask

  // The strobe is high during the CLK_DIV-th cycle after release, so it is
  // seen on negedge CLK_DIV-1 and acted upon by the CLK_DIV-th rising edge.
  task automatic test_release();
    int first_a = -1, first_b = -1;
    bit fs_a = 1'b0, fs_b = 1'b0;
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK100MHZ);
      if (a_ce && first_a < 0) begin first_a = i; fs_a = a_fs; end
      if (b_ce && first_b < 0) begin first_b = i; fs_b = b_fs; end
    end
    n_checks++;
    if (first_a != 3) begin
      n_fail++;
      $display("FAIL first_ce_a got %0d want 3", first_a);
    end
    n_checks++;
    if (first_b != 1) begin
      n_fail++;
      $display("FAIL first_ce_b got %0d want 1", first_b);
    end
    n_checks++;
    if ({fs_a, fs_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL first_frame_start got %b want 11", {fs_a, fs_b});
    end
  endtask

  task automatic test_periods();
    bit ok;
    int t0, t1;
    next_ce(0, ok); t0 = cyc;
    next_ce(0, ok); t1 = cyc;
    n_checks++;
    if (t1 - t0 != 4) begin n_fail++; $display("FAIL ce_period_a got %0d want 4", t1 - t0); end
    next_ce(1, ok); t0 = cyc;
    next_ce(1, ok); t1 = cyc;
    n_checks++;
    if (t1 - t0 != 2) begin n_fail++; $display("FAIL ce_period_b got %0d want 2", t1 - t0); end
    goto_pixel(0, 0, 1, ok); t0 = cyc;
    goto_pixel(0, 0, 2, ok); t1 = cyc;
    n_checks++;
    if (t1 - t0 != HT * 4) begin n_fail++; $display("FAIL line_period_a got %0d want %0d", t1 - t0, HT * 4); end
    goto_pixel(0, 0, 0, ok); t0 = cyc;
    n_checks++;
    if (a_fs !== 1'b1) begin n_fail++; $display("FAIL frame_start_at_origin got %b want 1", a_fs); end
    goto_pixel(0, 0, 0, ok); t1 = cyc;
    n_checks++;
    if (t1 - t0 != HT * VT * 4) begin n_fail++; $display("FAIL frame_period_a got %0d want %0d", t1 - t0, HT * VT * 4); end
    goto_pixel(1, 0, 0, ok); t0 = cyc;
    goto_pixel(1, 0, 0, ok); t1 = cyc;
    n_checks++;
    if (t1 - t0 != HT * VT * 2) begin n_fail++; $display("FAIL frame_period_b got %0d want %0d", t1 - t0, HT * VT * 2); end
  endtask

  // Active-low HS should cover pixels 42..45 (HA+HF .. HA+HF+HS-1).
  task automatic test_syncs();
    bit ok;
    int low_cnt = 0, first_low = -1;
    bit [3:0] vs_seen;
    goto_pixel(0, 0, 5, ok);
    for (int h = 0; h < HT; h++) begin
      if (h > 0) next_ce(0, ok);
      @(negedge CLK100MHZ);
      if (a_hs == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = h;
      end
    end
    n_checks++;
    if (low_cnt != 4) begin n_fail++; $display("FAIL hs_width got %0d want 4", low_cnt); end
    n_checks++;
    if (first_low != 42) begin n_fail++; $display("FAIL hs_start got %0d want 42", first_low); end
    for (int v = 0; v < 4; v++) begin
      goto_pixel(0, 0, 34 + v, ok);
      @(negedge CLK100MHZ);
      vs_seen[v] = a_vs;
    end
    n_checks++;
    if (vs_seen !== 4'b1001) begin n_fail++; $display("FAIL vs_lines34to37 got %b want 1001", vs_seen); end
  endtask

  task automatic test_ext_blank();
    bit ok;
    ext_r = 4'h5; ext_g = 4'hA; ext_b = 4'h3;
    goto_pixel(0, 10, 3, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if ({a_r, a_g, a_b} !== 12'h5A3) begin n_fail++; $display("FAIL ext_active got %h want 5a3", {a_r, a_g, a_b}); end
    goto_pixel(0, 39, 3, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if ({a_r, a_g, a_b} !== 12'h5A3) begin n_fail++; $display("FAIL ext_last_active got %h want 5a3", {a_r, a_g, a_b}); end
    goto_pixel(0, 40, 3, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if ({a_r, a_g, a_b} !== 12'h000) begin n_fail++; $display("FAIL hblank got %h want 000", {a_r, a_g, a_b}); end
    goto_pixel(0, 10, 34, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if ({a_r, a_g, a_b} !== 12'h000) begin n_fail++; $display("FAIL vblank got %h want 000", {a_r, a_g, a_b}); end
  endtask

  task automatic test_pol_div();
    bit ok;
    ext_r = 4'h5;
    goto_pixel(1, 0, 1, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if (b_r !== 4'h5) begin n_fail++; $display("FAIL b_first_pixel_r got %h want 5", b_r); end
    goto_pixel(1, 10, 1, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if (b_hs !== 1'b0) begin n_fail++; $display("FAIL b_hs_idle got %b want 0", b_hs); end
    goto_pixel(1, 43, 1, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if (b_hs !== 1'b1) begin n_fail++; $display("FAIL b_hs_active got %b want 1", b_hs); end
    goto_pixel(1, 0, 35, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if (b_vs !== 1'b1) begin n_fail++; $display("FAIL b_vs_active got %b want 1", b_vs); end
  endtask

`ifndef VGA_PATTERN_EN
  task automatic test_mode_ignored();
    bit ok;
    mode  = 2'd3;
    ext_r = 4'h1; ext_g = 4'h2; ext_b = 4'h3;
    goto_pixel(0, 0, 0, ok);
    goto_pixel(0, 10, 2, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if ({a_r, a_g, a_b} !== 12'h123) begin n_fail++; $display("FAIL mode_ignored got %h want 123", {a_r, a_g, a_b}); end
    mode = 2'd0;
  endtask
`else
  // With HA=40 each bar is 5 pixels wide: bar index = x/5, colour code 7-index.
  task automatic test_bars();
    bit ok;
    int xs [7]    = '{0, 4, 5, 34, 35, 39, 40};
    bit [11:0] ex [7] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h00F, 12'h000, 12'h000, 12'h000};
    mode = 2'd1;
    for (int i = 0; i < 7; i++) begin
      goto_pixel(0, xs[i], 0, ok);
      @(negedge CLK100MHZ);
      n_checks++;
      if ({a_r, a_g, a_b} !== ex[i]) begin
        n_fail++;
        $display("FAIL bars x=%0d got %h want %h", xs[i], {a_r, a_g, a_b}, ex[i]);
      end
    end
  endtask

  // Squares follow x[5]^y[5]; mode switched mid-frame only applies next frame.
  task automatic test_mode_switch();
    bit ok;
    int xs [6]    = '{32, 32, 32, 5, 32, 0};
    int ys [6]    = '{33, 0, 0, 5, 32, 33};
    bit [11:0] ex [6] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF};
    mode = 2'd3;
    goto_pixel(0, 0, 0, ok);
    @(negedge CLK100MHZ);
    n_checks++;
    if ({a_r, a_g, a_b} !== 12'hFFF) begin n_fail++; $display("FAIL white_origin got %h want fff", {a_r, a_g, a_b}); end
    goto_pixel(0, 32, 20, ok);
    mode = 2'd2;
    for (int i = 0; i < 6; i++) begin
      // index 1 is only a positioning step onto the next frame start
      goto_pixel(0, (i == 1) ? 0 : xs[i], ys[i], ok);
      @(negedge CLK100MHZ);
      if (i != 1) begin
        n_checks++;
        if ({a_r, a_g, a_b} !== ex[i]) begin
          n_fail++;
          $display("FAIL check (%0d,%0d) got %h want %h", xs[i], ys[i], {a_r, a_g, a_b}, ex[i]);
        end
      end
    end
    mode = 2'd0;
  endtask
`endif

  task automatic test_reset_midframe();
    bit ok;
    int n = 0;
    mode  = 2'd0;
    ext_r = 4'h5; ext_g = 4'hA; ext_b = 4'h3;
    goto_pixel(0, 0, 0, ok);
    goto_pixel(0, 30, 20, ok);
    n_checks++;
    if ({a_r, a_g, a_b, a_hs} !== 13'h0B47) begin
      n_fail++;
      $display("FAIL pre_reset got %h want b47", {a_r, a_g, a_b, a_hs});
    end
    CPU_RESETN = 1'b0;
    #1;
    n_checks++;
    if ({a_x, a_y, a_ce, a_fs} !== 14'd0) begin
      n_fail++;
      $display("FAIL midreset_timing got x=%0d y=%0d ce=%b fs=%b want 0", a_x, a_y, a_ce, a_fs);
    end
    n_checks++;
    if ({a_r, a_g, a_b, a_hs, a_vs} !== 14'b00000000000011) begin
      n_fail++;
      $display("FAIL midreset_pins got %h want 0003", {a_r, a_g, a_b, a_hs, a_vs});
    end
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    do begin
      @(negedge CLK100MHZ);
      n++;
    end while (!a_fs && n < 20);
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL restart_frame_start got %0d want 3", n); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_periods();
    test_syncs();
    test_ext_blank();
    test_pol_div();
`ifndef VGA_PATTERN_EN
    test_mode_ignored();
`else
    test_bars();
    test_mode_switch();
`endif
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
